// File: rtl/present_key_schedule.sv
// PRESENT key-schedule engine: expands an 80- or 128-bit user key into round keys
// K1..K32, presenting one per valid/ready handshake.

module present_sbox (
    input  logic [3:0] x_i,
    output logic [3:0] y_c_o
);
    always_comb begin
        y_c_o = 4'h0;
        case (x_i)
            4'h0: y_c_o = 4'hC;
            4'h1: y_c_o = 4'h5;
            4'h2: y_c_o = 4'h6;
            4'h3: y_c_o = 4'hB;
            4'h4: y_c_o = 4'h9;
            4'h5: y_c_o = 4'h0;
            4'h6: y_c_o = 4'hA;
            4'h7: y_c_o = 4'hD;
            4'h8: y_c_o = 4'h3;
            4'h9: y_c_o = 4'hE;
            4'hA: y_c_o = 4'hF;
            4'hB: y_c_o = 4'h8;
            4'hC: y_c_o = 4'h4;
            4'hD: y_c_o = 4'h7;
            4'hE: y_c_o = 4'h1;
            default: y_c_o = 4'h2;
        endcase
    end
endmodule

module present_key_schedule #(
    parameter int unsigned KEY_WIDTH = 80
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    output logic [63:0]          round_key_o,
    output logic                 round_key_valid_o,
    input  logic                 round_key_ready_i,
    output logic [4:0]           round_idx_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int unsigned KW    = KEY_WIDTH;
    localparam int unsigned RK_W  = 64;
    localparam int unsigned IDX_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(31);

    if (KW != 80 && KW != 128) begin : g_bad_width
        $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
    end

    logic [0:0]       state_q, state_d;
    logic [KW-1:0]    key_q, key_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [KW-1:0]    key_rot;
    logic [KW-1:0]    key_upd;
    logic [IDX_W-1:0] rc;

    // Round counter for the key being produced is one ahead of the presented index.
    assign rc      = IDX_W'(cnt_q + IDX_W'(1));
    assign key_rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

    if (KW == 80) begin : g_k80
        logic [3:0] sbox_hi;
        present_sbox u_sbox_hi (.x_i(key_rot[79:76]), .y_c_o(sbox_hi));
        assign key_upd = {sbox_hi, key_rot[75:20], key_rot[19:15] ^ rc, key_rot[14:0]};
    end else begin : g_k128
        logic [3:0] sbox_hi;
        logic [3:0] sbox_lo;
        present_sbox u_sbox_hi (.x_i(key_rot[127:124]), .y_c_o(sbox_hi));
        present_sbox u_sbox_lo (.x_i(key_rot[123:120]), .y_c_o(sbox_lo));
        assign key_upd = {sbox_hi, sbox_lo, key_rot[119:67], key_rot[66:62] ^ rc, key_rot[61:0]};
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    key_d   = key_i;
                    cnt_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                if (round_key_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = key_upd;
                        cnt_d = IDX_W'(cnt_q + IDX_W'(1));
                    end
                end
            end
        endcase
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d == ST_EMIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign round_key_o       = key_q[KW-1 -: RK_W];
    assign round_key_valid_o = valid_q;
    assign round_idx_o       = cnt_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
endmodule

// File: tb/tb_present_key_schedule.sv
// Randomized bench for present_key_schedule (80- and 128-bit instances) against
// an arithmetic key-expansion model and a transaction-level handshake model.

module tb_present_key_schedule;
    logic clk;
    logic rst;

    logic          start80, ready80;
    logic [79:0]   key80;
    logic [63:0]   rk80;
    logic          v80, b80, d80;
    logic [4:0]    idx80;

    logic          start128, ready128;
    logic [127:0]  key128;
    logic [63:0]   rk128;
    logic          v128, b128, d128;
    logic [4:0]    idx128;

    int n_err = 0;
    int n_checks = 0;

    present_key_schedule #(.KEY_WIDTH(80)) dut80 (
        .clk_i(clk), .rst_i(rst), .start_i(start80), .key_i(key80),
        .round_key_o(rk80), .round_key_valid_o(v80), .round_key_ready_i(ready80),
        .round_idx_o(idx80), .busy_o(b80), .done_o(d80)
    );

    present_key_schedule #(.KEY_WIDTH(128)) dut128 (
        .clk_i(clk), .rst_i(rst), .start_i(start128), .key_i(key128),
        .round_key_o(rk128), .round_key_valid_o(v128), .round_key_ready_i(ready128),
        .round_idx_o(idx128), .busy_o(b128), .done_o(d128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // Round key K(r+1) of a w-bit user key, by applying r updates arithmetically.
    function automatic logic [63:0] model_rk(input int w, input logic [127:0] k0, input int r);
        logic [127:0] k, mask;
        logic [3:0]   n;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
        k = k0 & mask;
        for (int i = 1; i <= r; i++) begin
            k = ((k << 61) | (k >> (w - 61))) & mask;
            n = 4'(k >> (w - 4));
            k = (k & ~(128'hF << (w - 4))) | (128'(sbox(n)) << (w - 4));
            if (w == 128) begin
                n = 4'(k >> (w - 8));
                k = (k & ~(128'hF << (w - 8))) | (128'(sbox(n)) << (w - 8));
            end
            k = k ^ (128'(i) << ((w == 80) ? 15 : 62));
        end
        return 64'(k >> (w - 64));
    endfunction

    // Handshake model: index 0 is the 80-bit instance, 1 the 128-bit one.
    logic         m_busy[2];
    logic         m_done[2];
    logic         m_loaded[2];
    logic [4:0]   m_idx[2];
    logic [127:0] m_ukey[2];

    task automatic step(input int d, input logic s, input logic r, input logic [127:0] k);
        m_done[d] = 1'b0;
        if (m_busy[d]) begin
            if (r) begin
                if (m_idx[d] == 5'd31) begin
                    m_busy[d] = 1'b0;
                    m_done[d] = 1'b1;
                end else begin
                    m_idx[d] = m_idx[d] + 5'd1;
                end
            end
        end else if (s) begin
            m_busy[d]   = 1'b1;
            m_idx[d]    = 5'd0;
            m_ukey[d]   = k;
            m_loaded[d] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_done[d] = 1'b0; m_loaded[d] = 1'b0;
                m_idx[d] = 5'd0;  m_ukey[d] = '0;
            end
        end else begin
            step(0, start80, ready80, {48'd0, key80});
            step(1, start128, ready128, key128);
        end
    end

    function automatic logic [63:0] exp_rk(input int d);
        if (!m_loaded[d]) return 64'd0;
        return model_rk((d == 0) ? 80 : 128, m_ukey[d], int'(m_idx[d]));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("k80 round_key", rk80, exp_rk(0));
        chk("k80 round_idx", 64'(idx80), 64'(m_idx[0]));
        chk("k80 valid", 64'(v80), 64'(m_busy[0]));
        chk("k80 busy", 64'(b80), 64'(m_busy[0]));
        chk("k80 done", 64'(d80), 64'(m_done[0]));
        chk("k128 round_key", rk128, exp_rk(1));
        chk("k128 round_idx", 64'(idx128), 64'(m_idx[1]));
        chk("k128 valid", 64'(v128), 64'(m_busy[1]));
        chk("k128 busy", 64'(b128), 64'(m_busy[1]));
        chk("k128 done", 64'(d128), 64'(m_done[1]));
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input int d, input logic s, input logic r, input logic [127:0] k);
        if (d == 0) begin
            start80 = s; ready80 = r; key80 = k[79:0];
        end else begin
            start128 = s; ready128 = r; key128 = k;
        end
    endtask

    // One-cycle start pulse; key input is scrambled afterwards to prove one-time sampling.
    task automatic start_key(input int d, input logic [127:0] k);
        drive(d, 1'b1, 1'b0, k);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, rand128());
    endtask

    // Runs the handshake until done pulses; optional start injection at index inj.
    task automatic run_to_done(input int d, input bit rnd, input int inj, input logic [127:0] ikey);
        int  cyc;
        logic r;
        logic s;
        cyc = 0;
        while (!m_done[d] && cyc < 300) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s = (m_busy[d] && int'(m_idx[d]) == inj);
            drive(d, s, r, s ? ikey : rand128());
            @(posedge clk); #1;
            cyc++;
        end
        drive(d, 1'b0, 1'b0, rand128());
        n_checks++;
        if (!m_done[d]) begin
            n_err++;
            $display("FAIL run_to_done timeout dut=%0d: got no done expected done within 300 cycles", d);
        end
    endtask

    initial begin
        logic [127:0] k;
        int c;
        start80 = 0; ready80 = 0; key80 = '0;
        start128 = 0; ready128 = 0; key128 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset k80 round_key", rk80, 64'd0);
        chk("reset k80 idx", 64'(idx80), 64'd0);
        chk("reset k128 round_key", rk128, 64'd0);
        chk("reset k128 valid/busy/done", 64'({v128, b128, d128}), 64'd0);
        rst = 1'b0;

        chk("model k80 K1", model_rk(80, 128'd0, 0), 64'h0000000000000000);
        chk("model k80 K2", model_rk(80, 128'd0, 1), 64'hC000000000000000);
        chk("model k80 K3", model_rk(80, 128'd0, 2), 64'h5000180000000001);
        chk("model k80 K32", model_rk(80, 128'd0, 31), 64'h6DAB31744F41D700);
        chk("model k128 K2", model_rk(128, 128'd0, 1), 64'hCC00000000000000);

        @(posedge clk); #1;
        // Zero key, ready held high: 32 back-to-back keys.
        start_key(0, 128'd0);
        chk("k80 K1 after start", rk80, 64'd0);
        run_to_done(0, 1'b0, -1, '0);
        chk("k80 K32 held at done", rk80, 64'h6DAB31744F41D700);
        chk("k80 done pulse", 64'(d80), 64'd1);
        @(posedge clk); #1;

        // Zero key, random ready.
        start_key(0, 128'd0);
        run_to_done(0, 1'b1, -1, '0);
        @(posedge clk); #1;

        // Start with another key mid-sequence is ignored.
        start_key(0, rand128());
        run_to_done(0, 1'b1, 10, rand128());
        @(posedge clk); #1;

        // Asynchronous reset at index 15.
        start_key(0, rand128());
        c = 0;
        while (!(m_busy[0] && m_idx[0] == 5'd15) && c < 200) begin
            drive(0, 1'b0, 1'($urandom_range(0, 1)), rand128());
            @(posedge clk); #1;
            c++;
        end
        chk("k80 reached idx15", 64'(idx80), 64'd15);
        #1 rst = 1'b1;
        #1;
        chk("async rst k80 round_key", rk80, 64'd0);
        chk("async rst k80 idx/valid/busy/done", 64'({idx80, v80, b80, d80}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        k = rand128();
        start_key(0, k);
        chk("k80 K1 after reset restart", rk80, k[79:16]);
        run_to_done(0, 1'b1, -1, '0);

        // Restart in the done cycle with an all-ones key.
        drive(0, 1'b1, 1'b0, {128{1'b1}});
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, rand128());
        chk("k80 K1 all-ones restart", rk80, 64'hFFFFFFFFFFFFFFFF);
        chk("k80 single done", 64'(d80), 64'd0);
        run_to_done(0, 1'b1, -1, '0);
        @(posedge clk); #1;

        // 128-bit instance.
        start_key(1, 128'd0);
        chk("k128 K1 zero", rk128, 64'd0);
        drive(1, 1'b0, 1'b1, '0);
        @(posedge clk); #1;
        chk("k128 K2 zero", rk128, 64'hCC00000000000000);
        run_to_done(1, 1'b0, -1, '0);
        @(posedge clk); #1;
        start_key(1, rand128());
        run_to_done(1, 1'b1, 10, rand128());
        k = rand128();
        drive(1, 1'b1, 1'b0, k);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, rand128());
        chk("k128 K1 done-cycle restart", rk128, k[127:64]);
        run_to_done(1, 1'b1, -1, '0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/present_key_schedule.md
Name: present_key_schedule

Overview:
Iterative PRESENT key-schedule engine that expands a user key into the 32 64-bit round keys consumed by the addRoundKey stage of the round datapath. Each update instantiates the 4-bit PRESENT S-box (one nibble for 80-bit keys, two nibbles for 128-bit keys). It emits one round key per accepted valid/ready handshake, in order K1..K32, so the round engine can pace it.

Parameters:
KEY_WIDTH, 80, user key length; legal values 80 or 128; any other value is an elaboration error.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
start_i  input  1  load key_i and begin expansion; honoured only in IDLE
key_i  input  KEY_WIDTH  user key; sampled on the cycle start_i is accepted
round_key_o  output  64  current round key, KEY_REG[KEY_WIDTH-1 -: 64]
round_key_valid_o  output  1  round_key_o holds K(round_idx_o+1)
round_key_ready_i  input  1  consumer accepts round_key_o this cycle
round_idx_o  output  5  index of presented key minus 1 (0 = K1, 31 = K32)
busy_o  output  1  high from start acceptance until K32 accepted
done_o  output  1  one-cycle pulse the cycle after K32 is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, KEY_REG=0, counter=0, all outputs 0.
- States: IDLE, EMIT.
- IDLE: busy_o=0, valid=0. start_i=1 -> KEY_REG<=key_i, counter<=0, go EMIT next edge; K1 valid the cycle after start (1-cycle latency).
- EMIT: valid=1, busy_o=1, round_key_o=top 64 bits of KEY_REG, round_idx_o=counter.
- valid & ready with counter<31: KEY_REG<=update(KEY_REG, counter+1); counter<=counter+1; valid stays 1 (back-to-back keys at 1 per cycle when ready held high).
- valid & ready with counter==31: go IDLE, valid<=0, busy_o<=0, done_o pulses 1 cycle; KEY_REG and round_idx_o hold.
- valid & !ready: round_key_o, round_idx_o stable; no update.
- update, KEY_WIDTH=80, round counter rc (5 bits, 1..31): K<=K rotated left 61; K[79:76]<=S(K[79:76]); K[19:15]<=K[19:15]^rc.
- update, KEY_WIDTH=128: K<=K rotl 61; K[127:124]<=S(K[127:124]); K[123:120]<=S(K[123:120]); K[66:62]<=K[66:62]^rc.
- S is the standard PRESENT S-box (0->C, 1->5, ... F->2); instantiated, not re-tabulated.
- start_i while busy_o=1: ignored, no effect on sequence; start_i in same cycle done_o pulses is honoured (state already IDLE).
- Reset mid-expansion: immediate abort to IDLE, no done_o.
- round_key_o is a direct register slice; no combinational path from round_key_ready_i to round_key_o.

Test Plan:
- 80-bit zero key, ready tied high: start_i one cycle -> K1=0000000000000000, K2=C000000000000000, K3=5000180000000001, ..., K32=6DAB31744F41D700 on 32 consecutive cycles; done_o pulses once the cycle after K32.
- Same zero key with ready toggled pseudo-randomly -> identical K1..K32 sequence; round_key_o/round_idx_o unchanged on every stalled cycle.
- start_i reasserted with a different key at round_idx_o=10 -> ignored; sequence continues for original key to K32.
- rst_i asserted mid-cycle at round_idx_o=15 -> outputs 0 asynchronously; new start after release reproduces K1 of new key; no done_o.
- KEY_WIDTH=128, zero key -> K1=0, K2=CC00000000000000 (two S-box nibbles), counter injected at bits 66:62; sequence completes with done_o after 32 accepts.
- start_i in the done_o cycle with key FFFF...F (80-bit) -> K1=FFFFFFFFFFFFFFFF presented next cycle, no lost or extra done_o.
